// File: rtl/mult_operand_sequencer_pkg.sv
// Shared definitions for the multiplier operand sequencer: FSM encoding,
// default sizing and the counter-width helper.
package mult_pkg;

    localparam int DATA_W_DEF     = 4;
    localparam int DEB_CYCLES_DEF = 250000;
    localparam int TIMEOUT_DEF    = 64;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CAPTURE = 3'd1;
    localparam logic [2:0] ST_LAUNCH  = 3'd2;
    localparam logic [2:0] ST_WAIT    = 3'd3;
    localparam logic [2:0] ST_ACK     = 3'd4;
    localparam logic [2:0] ST_SHOW    = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE    = ST_IDLE,
        S_CAPTURE = ST_CAPTURE,
        S_LAUNCH  = ST_LAUNCH,
        S_WAIT    = ST_WAIT,
        S_ACK     = ST_ACK,
        S_SHOW    = ST_SHOW
    } seq_state_e;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mult_key_debounce.sv
// Key conditioner: 2-FF synchronizer followed by a stable-count debouncer.
// Emits the debounced level and a one-cycle pulse on its rising edge.
module mult_key_debounce
    import mult_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_level,
    output logic o_rise
);

    localparam int             CW       = cnt_w(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_rise;
    logic [CW-1:0] r_cnt;

    // The count only advances while the synchronized key disagrees with the
    // accepted level; any agreeing sample restarts the run.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/mult_operand_sequencer.sv
// Front-end for the shift-add multiplier: conditions keys/switches, launches
// the multiplier, completes Done/Ack and holds the product. Optional WAIT
// timeout is enabled with `define MULT_SEQ_TIMEOUT_EN.
module mult_operand_sequencer
    import mult_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
`ifdef MULT_SEQ_TIMEOUT_EN
    , parameter int TIMEOUT  = TIMEOUT_DEF
`endif
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [DATA_W-1:0]   Sw_Q,
    input  logic [DATA_W-1:0]   Sw_R,
    input  logic                Key_Go,
    input  logic                Key_Clr,
    input  logic                Mult_Done,
    input  logic [2*DATA_W-1:0] Mult_P,
    output logic [DATA_W-1:0]   Q_Out,
    output logic [DATA_W-1:0]   R_Out,
    output logic                Start,
    output logic                Ack,
    output logic [2*DATA_W-1:0] P_Hold,
    output logic                Result_Valid,
    output logic                Busy,
    output logic                Timeout_Err,
    output logic [2:0]          Dbg_State,
    output logic [1:0]          Dbg_Keys
);

    seq_state_e          r_state;
    seq_state_e          w_next;
    logic [DATA_W-1:0]   r_swq1, r_swq2, r_swr1, r_swr2;
    logic [DATA_W-1:0]   r_q, r_r;
    logic [2*DATA_W-1:0] r_p;
    logic                r_valid;
    logic                w_go_p, w_clr_p, w_go_lvl, w_clr_lvl;
    logic                w_capture, w_clear, w_latch_p, w_finish;

    mult_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_go_deb (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_key   (Key_Go),
        .o_level (w_go_lvl),
        .o_rise  (w_go_p)
    );

    mult_key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_clr_deb (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .i_key   (Key_Clr),
        .o_level (w_clr_lvl),
        .o_rise  (w_clr_p)
    );

`ifdef MULT_SEQ_TIMEOUT_EN
    localparam int             TCW       = cnt_w(TIMEOUT);
    localparam logic [TCW-1:0] TCNT_LAST = TCW'(TIMEOUT - 1);
    logic [TCW-1:0] r_tcnt;
    logic           r_terr;
    logic           w_timeout;
`endif

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_clear   = 1'b0;
        w_latch_p = 1'b0;
        w_finish  = 1'b0;
`ifdef MULT_SEQ_TIMEOUT_EN
        w_timeout = 1'b0;
`endif
        case (r_state)
            S_IDLE, S_SHOW: begin
                // CLR takes priority over a simultaneous GO.
                if (w_clr_p) begin
                    w_next  = S_IDLE;
                    w_clear = 1'b1;
                end else if (w_go_p) begin
                    w_next    = S_CAPTURE;
                    w_capture = 1'b1;
                end
            end
            S_CAPTURE: w_next = S_LAUNCH;
            S_LAUNCH:  w_next = S_WAIT;
            S_WAIT: begin
                if (Mult_Done) begin
                    w_next    = S_ACK;
                    w_latch_p = 1'b1;
                end
`ifdef MULT_SEQ_TIMEOUT_EN
                else if (r_tcnt == TCNT_LAST) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
`endif
            end
            S_ACK: begin
                if (!Mult_Done) begin
                    w_next   = S_SHOW;
                    w_finish = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_swq1  <= '0;
            r_swq2  <= '0;
            r_swr1  <= '0;
            r_swr2  <= '0;
            r_q     <= '0;
            r_r     <= '0;
            r_p     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_swq1  <= Sw_Q;
            r_swq2  <= r_swq1;
            r_swr1  <= Sw_R;
            r_swr2  <= r_swr1;
            if (w_capture) begin
                r_q     <= r_swq2;
                r_r     <= r_swr2;
                r_valid <= 1'b0;
            end
            if (w_clear) begin
                r_q     <= '0;
                r_r     <= '0;
                r_p     <= '0;
                r_valid <= 1'b0;
            end
            if (w_latch_p) r_p     <= Mult_P;
            if (w_finish)  r_valid <= 1'b1;
        end
    end

`ifdef MULT_SEQ_TIMEOUT_EN
    // Held at zero outside WAIT, so it restarts from zero on every entry.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_tcnt <= '0;
            r_terr <= 1'b0;
        end else begin
            r_tcnt <= (r_state == S_WAIT) ? r_tcnt + 1'b1 : '0;
            if (w_timeout)                   r_terr <= 1'b1;
            else if (w_capture || w_clear)   r_terr <= 1'b0;
        end
    end
    assign Timeout_Err = r_terr;
`else
    assign Timeout_Err = 1'b0;
`endif

    assign Q_Out        = r_q;
    assign R_Out        = r_r;
    assign P_Hold       = r_p;
    assign Result_Valid = r_valid;
    assign Start        = (r_state == S_LAUNCH);
    assign Ack          = (r_state == S_ACK);
    assign Busy         = (r_state == S_CAPTURE) || (r_state == S_LAUNCH) ||
                          (r_state == S_WAIT)    || (r_state == S_ACK);
    assign Dbg_State    = r_state;
    assign Dbg_Keys     = {w_clr_lvl, w_go_lvl};

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with a behavioural multiplier
// that answers Start after a programmable delay.
module tb_mult_operand_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd3;
    localparam logic [2:0] ST_SHOW = 3'd5;

    logic       Clock;
    logic       Reset;
    logic [3:0] Sw_Q, Sw_R;
    logic       Key_Go, Key_Clr;
    logic       Mult_Done;
    logic [7:0] Mult_P;
    logic [3:0] Q_Out, R_Out;
    logic       Start, Ack;
    logic [7:0] P_Hold;
    logic       Result_Valid, Busy, Timeout_Err;
    logic [2:0] Dbg_State;
    logic [1:0] Dbg_Keys;

    int checks = 0;
    int errors = 0;

    // Multiplier model controls
    logic       mdl_en    = 1'b1;
    logic       mdl_hold  = 1'b0;
    int         mdl_delay = 10;
    logic [7:0] mdl_p     = 8'd0;
    int         mdl_cnt   = 0;
    int         start_cnt = 0;

    mult_operand_sequencer #(
        .DATA_W(4),
        .DEB_CYCLES(4)
`ifdef MULT_SEQ_TIMEOUT_EN
        , .TIMEOUT(16)
`endif
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Sw_Q         (Sw_Q),
        .Sw_R         (Sw_R),
        .Key_Go       (Key_Go),
        .Key_Clr      (Key_Clr),
        .Mult_Done    (Mult_Done),
        .Mult_P       (Mult_P),
        .Q_Out        (Q_Out),
        .R_Out        (R_Out),
        .Start        (Start),
        .Ack          (Ack),
        .P_Hold       (P_Hold),
        .Result_Valid (Result_Valid),
        .Busy         (Busy),
        .Timeout_Err  (Timeout_Err),
        .Dbg_State    (Dbg_State),
        .Dbg_Keys     (Dbg_Keys)
    );

    // Clock / reset block
    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Multiplier model: raises Done mdl_delay cycles after Start, drops it
    // once Ack is seen (unless told to hold it).
    initial begin
        Mult_Done = 1'b0;
        Mult_P    = 8'd0;
        forever begin
            @(posedge Clock);
            #2;
            if (Start) start_cnt++;
            if (!mdl_en) begin
                Mult_Done = 1'b0;
                mdl_cnt   = 0;
            end else begin
                if (mdl_cnt > 0) begin
                    mdl_cnt--;
                    if (mdl_cnt == 0) begin
                        Mult_Done = 1'b1;
                        Mult_P    = mdl_p;
                    end
                end
                if (Start) mdl_cnt = mdl_delay;
                if (Mult_Done && Ack && !mdl_hold) Mult_Done = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Counts edges until Start; also notes when the debounced GO pulse fired.
    task automatic wait_start(output int lat, output int go_lat);
        lat    = 0;
        go_lat = -1;
        while (lat < 40 && !Start) begin
            tick();
            lat++;
            if (dut.w_go_p) go_lat = lat;
        end
        check("start_seen", Start, 1'b1);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (n < 80 && !Result_Valid) begin
            tick();
            n++;
        end
        check("valid_seen", Result_Valid, 1'b1);
    endtask

    initial begin
        int lat, go_lat, n, sc;
        Reset   = 1'b0;
        Sw_Q    = 4'd0;
        Sw_R    = 4'd0;
        Key_Go  = 1'b0;
        Key_Clr = 1'b0;
        repeat (3) tick();
        check("rst_state", Dbg_State, ST_IDLE);
        check("rst_start", Start, 1'b0);
        check("rst_ack", Ack, 1'b0);
        check("rst_phold", P_Hold, 8'd0);
        check("rst_q", Q_Out, 4'd0);
        check("rst_busy", Busy, 1'b0);
        check("rst_valid", Result_Valid, 1'b0);
        check("rst_terr", Timeout_Err, 1'b0);
        Reset = 1'b1;
        repeat (2) tick();

        // 1: clean press, 13 x 11
        Sw_Q = 4'd13; Sw_R = 4'd11; mdl_p = 8'd143; mdl_delay = 10;
        repeat (3) tick();
        Key_Go = 1'b1;
        wait_start(lat, go_lat);
        check("t1_latency", lat, 8);
        check("t1_q", Q_Out, 4'd13);
        check("t1_r", R_Out, 4'd11);
        check("t1_busy", Busy, 1'b1);
        Key_Go = 1'b0;
        tick();
        check("t1_start_1cyc", Start, 1'b0);
        n = 0;
        while (n < 30 && !Ack) begin tick(); n++; end
        check("t1_ack", Ack, 1'b1);
        check("t1_ack_lat", n, 10);
        check("t1_phold_at_ack", P_Hold, 8'd143);
        wait_valid();
        check("t1_ack_drop", Ack, 1'b0);
        check("t1_phold", P_Hold, 8'd143);
        check("t1_state", Dbg_State, ST_SHOW);
        check("t1_busy_off", Busy, 1'b0);
        check("t1_starts", start_cnt, 1);

        // 2: bouncing GO then steady press
        repeat (8) tick();
        mdl_delay = 30;
        Key_Go = 1'b1; tick();
        Key_Go = 1'b0; tick();
        Key_Go = 1'b1; tick();
        Key_Go = 1'b0; tick();
        check("t2_no_start_bounce", start_cnt, 1);
        Key_Go = 1'b1;
        wait_start(lat, go_lat);
        check("t2_latency", lat, 8);
        check("t2_go_to_start", lat - go_lat, 2);
        check("t2_valid_cleared", Result_Valid, 1'b0);

        // 3: second press and switch change while WAITing
        Key_Go = 1'b0;
        repeat (8) tick();
        Key_Go = 1'b1;
        Sw_Q   = 4'd2;
        repeat (8) tick();
        check("t3_in_wait", Dbg_State, ST_WAIT);
        check("t3_q_hold", Q_Out, 4'd13);
        wait_valid();
        check("t3_starts", start_cnt, 2);
        check("t3_q_after", Q_Out, 4'd13);
        check("t3_phold", P_Hold, 8'd143);
        repeat (10) tick();
        check("t3_no_queue", start_cnt, 2);
        check("t3_show", Dbg_State, ST_SHOW);

        // 4: GO and CLR together in SHOW
        Key_Go = 1'b0;
        repeat (10) tick();
        sc = start_cnt;
        Key_Go  = 1'b1;
        Key_Clr = 1'b1;
        repeat (12) tick();
        check("t4_state", Dbg_State, ST_IDLE);
        check("t4_phold", P_Hold, 8'd0);
        check("t4_valid", Result_Valid, 1'b0);
        check("t4_q", Q_Out, 4'd0);
        check("t4_r", R_Out, 4'd0);
        check("t4_no_start", start_cnt, sc);
        Key_Go  = 1'b0;
        Key_Clr = 1'b0;
        repeat (10) tick();

        // 5: reset while in ACK
        Sw_Q = 4'd7; Sw_R = 4'd9; mdl_p = 8'd63; mdl_delay = 5; mdl_hold = 1'b1;
        repeat (3) tick();
        Key_Go = 1'b1;
        wait_start(lat, go_lat);
        Key_Go = 1'b0;
        n = 0;
        while (n < 30 && !Ack) begin tick(); n++; end
        tick();
        check("t5_ack_held", Ack, 1'b1);
        check("t5_phold_pre", P_Hold, 8'd63);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("t5_ack", Ack, 1'b0);
        check("t5_busy", Busy, 1'b0);
        check("t5_phold", P_Hold, 8'd0);
        check("t5_state", Dbg_State, ST_IDLE);
        check("t5_q", Q_Out, 4'd0);
        mdl_en = 1'b0;
        tick();
        mdl_en   = 1'b1;
        mdl_hold = 1'b0;
        repeat (10) tick();

`ifdef MULT_SEQ_TIMEOUT_EN
        // 6: Done never arrives
        mdl_en = 1'b0;
        Key_Go = 1'b1;
        wait_start(lat, go_lat);
        Key_Go = 1'b0;
        repeat (16) tick();
        check("t6_still_wait", Dbg_State, ST_WAIT);
        check("t6_no_err_yet", Timeout_Err, 1'b0);
        tick();
        check("t6_err", Timeout_Err, 1'b1);
        check("t6_idle", Dbg_State, ST_IDLE);
        check("t6_no_ack", Ack, 1'b0);
        mdl_en = 1'b1; mdl_delay = 4; mdl_p = 8'd6;
        Sw_Q = 4'd2; Sw_R = 4'd3;
        repeat (8) tick();
        check("t6_err_sticky", Timeout_Err, 1'b1);
        Key_Go = 1'b1;
        wait_start(lat, go_lat);
        check("t6_err_cleared", Timeout_Err, 1'b0);
        Key_Go = 1'b0;
        wait_valid();
        check("t6_phold", P_Hold, 8'd6);
`else
        check("terr_tied", Timeout_Err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
